// File: rtl/ram_sp_init.sv
// ram_sp_init: parametrised single-port RAM with lane write enables, 1/2-cycle read latency,
// read-valid strobe and an optional post-reset clear sweep enabled by RAM_INIT_EN
module ram_sp_init #(
    parameter int DW = 18,
    parameter int AW = 11,
    parameter int LW = 9,
    parameter int RD_LAT = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              ce,
    input  logic              we,
    input  logic [DW/LW-1:0]  be,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     di,
    output logic [DW-1:0]     dout,
    output logic              rvld,
    output logic              busy
);
    localparam int NL = DW / LW;
    localparam int DEPTH = 2 ** AW;

    if (DW % LW != 0) begin : g_bad_lw
        $error("ram_sp_init: DW must be a multiple of LW");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("ram_sp_init: RD_LAT must be 1 or 2");
    end

    logic [DW-1:0] mem [DEPTH];
    logic          sweep;
    logic [AW-1:0] cnt;
    logic          rd_acc;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NL-1:0] wr_be;
    logic [DW-1:0] d1;
    logic          v1;

`ifdef RAM_INIT_EN
    typedef enum logic {SWEEP, RUN} state_t;
    state_t state, state_nx;

    // state register: reset always restarts the clear sweep
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) state <= SWEEP;
        else state <= state_nx;
    end

    // next state: leave SWEEP once the last word has been written
    always_comb begin
        state_nx = (state == SWEEP && cnt == '1) ? RUN : state;
    end

    // sweep address counter, frozen once the top word is reached
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) cnt <= '0;
        else if (state == SWEEP && cnt != '1) cnt <= cnt + AW'(1);
    end

    // outputs: the array is owned by the sweep while in SWEEP
    always_comb begin
        sweep = (state == SWEEP);
    end
`else
    assign sweep = 1'b0;
    assign cnt = '0;
`endif

    assign busy = sweep;

    // steer the single write port between the sweep and user requests
    always_comb begin
        rd_acc = ce & ~we & ~sweep;
        wr_en = sweep | (ce & we);
        wr_addr = sweep ? cnt : addr;
        wr_data = sweep ? INIT_VAL : di;
        wr_be = sweep ? '1 : be;
    end

    // array write with per-lane enables; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < NL; i++)
                if (wr_be[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
    end

    // first read stage: data only updates on an accepted read so it holds otherwise
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= mem[addr];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DW-1:0] d2;
        logic          v2;
        // optional output register for timing, also holding between reads
        always_ff @(posedge clk or negedge rst_x) begin
            if (!rst_x) begin
                d2 <= '0;
                v2 <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end
        assign dout = d2;
        assign rvld = v2;
    end else begin : g_lat1
        assign dout = d1;
        assign rvld = v1;
    end
endmodule

// File: tb/tb_ram_sp_init.sv
// tb_ram_sp_init: scoreboard bench driving one RD_LAT=1 and one RD_LAT=2 instance in lockstep
module tb_ram_sp_init;
    logic clk = 0, rst_x = 1, ce = 0, we = 0;
    logic [1:0] be = 0;
    logic [10:0] addr = 0;
    logic [17:0] di = 0;
    logic [17:0] do1, do2;
    logic rv1, rv2, bz1, bz2;
    int total = 0, bad = 0, cyc = 0, n;
    typedef struct {int due; logic [17:0] d;} sb_t;
    sb_t q1[$], q2[$];
    logic [17:0] model [int];
`ifdef RAM_INIT_EN
    localparam bit INIT = 1;
`else
    localparam bit INIT = 0;
`endif

    ram_sp_init #(.RD_LAT(1)) u1 (.clk(clk), .rst_x(rst_x), .ce(ce), .we(we), .be(be),
        .addr(addr), .di(di), .dout(do1), .rvld(rv1), .busy(bz1));
    ram_sp_init #(.RD_LAT(2)) u2 (.clk(clk), .rst_x(rst_x), .ce(ce), .we(we), .be(be),
        .addr(addr), .di(di), .dout(do2), .rvld(rv2), .busy(bz2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            chk("rvld_lat1", {31'b0, rv1}, 1);
            chk("do_lat1", {14'b0, do1}, {14'b0, q1[0].d});
            void'(q1.pop_front());
        end else chk("idle_lat1", {31'b0, rv1}, 0);
        if (q2.size() > 0 && q2[0].due == cyc) begin
            chk("rvld_lat2", {31'b0, rv2}, 1);
            chk("do_lat2", {14'b0, do2}, {14'b0, q2[0].d});
            void'(q2.pop_front());
        end else chk("idle_lat2", {31'b0, rv2}, 0);
    end

    task automatic drive(input logic c, input logic w, input logic [1:0] b,
                         input logic [10:0] a, input logic [17:0] d);
        @(posedge clk);
        #1;
        ce = c; we = w; be = b; addr = a; di = d;
    endtask

    function automatic logic [17:0] peek(input int a);
        return model.exists(a) ? model[a] : (INIT ? 18'h0 : 18'hx);
    endfunction

    task automatic wr(input logic [10:0] a, input logic [17:0] d, input logic [1:0] b);
        logic [17:0] m;
        drive(1, 1, b, a, d);
        m = peek(int'(a));
        if (b[0]) m[8:0] = d[8:0];
        if (b[1]) m[17:9] = d[17:9];
        model[int'(a)] = m;
    endtask

    task automatic rd(input logic [10:0] a);
        logic [17:0] e;
        drive(1, 0, 2'b00, a, 18'h0);
        e = peek(int'(a));
        q1.push_back('{cyc + 1, e});
        q2.push_back('{cyc + 2, e});
    endtask

    task automatic idle();
        drive(0, 0, 2'b00, 11'h0, 18'h0);
    endtask

    initial begin
        #1 rst_x = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_do1", {14'b0, do1}, 0);
        chk("rst_do2", {14'b0, do2}, 0);
        chk("rst_busy1", {31'b0, bz1}, {31'b0, INIT});
        chk("rst_busy2", {31'b0, bz2}, {31'b0, INIT});
        rst_x = 1;
`ifdef RAM_INIT_EN
        for (int i = 0; i < 100; i++) begin
            if (i == 3) drive(1, 1, 2'b11, 11'h005, 18'h12345);
            else if (i == 4) drive(1, 0, 2'b00, 11'h005, 18'h0);
            else idle();
        end
        chk("busy_mid_sweep", {31'b0, bz1}, 1);
        rst_x = 0;
        #1;
        chk("midrst_busy1", {31'b0, bz1}, 1);
        chk("midrst_busy2", {31'b0, bz2}, 1);
        chk("midrst_rvld", {30'b0, rv1, rv2}, 0);
        chk("midrst_do", {14'b0, do1 | do2}, 0);
        repeat (3) @(posedge clk);
        #1 rst_x = 1;
        n = 0;
        while (bz1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_len", n, 2048);
        chk("sweep_done2", {31'b0, bz2}, 0);
        rd(11'h000);
        rd(11'h400);
        rd(11'h7FF);
        rd(11'h005);
`endif
        wr(11'h7FF, 18'h3FFFF, 2'b11);
        rd(11'h7FF);
        wr(11'h010, 18'h00000, 2'b11);
        wr(11'h010, 18'h3FFFF, 2'b01);
        rd(11'h010);
        wr(11'h010, 18'h2AA00, 2'b10);
        rd(11'h010);
        wr(11'h010, 18'h12345, 2'b00);
        rd(11'h010);
        for (int i = 0; i < 4; i++) wr(11'(i), 18'(17 * (i + 1)), 2'b11);
        for (int i = 0; i < 4; i++) rd(11'(i));
        repeat (5) idle();
        chk("hold_do1", {14'b0, do1}, 32'h44);
        chk("hold_do2", {14'b0, do2}, 32'h44);
        wr(11'h009, 18'h2BEEF, 2'b11);
        repeat (3) idle();
        chk("hold_wr_do1", {14'b0, do1}, 32'h44);
        chk("hold_wr_do2", {14'b0, do2}, 32'h44);
        for (int i = 0; i < 8; i++) wr(11'(32 + i), 18'($urandom), 2'b11);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1) == 1)
                wr(11'(32 + $urandom_range(7)), 18'($urandom), 2'($urandom_range(3)));
            else rd(11'(32 + $urandom_range(7)));
        end
        idle();
        n = 0;
        while ((q1.size() > 0 || q2.size() > 0) && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", q1.size() + q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
